// File: rtl/dti_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : dti_fifo_pkg                                                 |
// | Purpose   : Shared types and helpers for the DTI FIFO burst scheduler:   |
// |             width-conversion ratio encoding, scheduler state encoding,   |
// |             and the ratio-to-step conversion used by the beat counter.   |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package dti_fifo_pkg;

   // Narrow words moved per datapath beat
   typedef enum logic [1:0] {
      RATIO_1    = 2'd0,
      RATIO_2    = 2'd1,
      RATIO_4    = 2'd2,
      RATIO_RSVD = 2'd3
   } ratio_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_XFER = 2'd2
   } sched_st_t;

   // Words consumed per beat; the reserved code never reaches the counter,
   // it maps to 1 only so the function is total.
   function automatic logic [2:0] ratio_step(input logic [1:0] ratio);
      logic [2:0] step;
      case (ratio_t'(ratio))
         RATIO_1: step = 3'd1;
         RATIO_2: step = 3'd2;
         RATIO_4: step = 3'd4;
         default: step = 3'd1;
      endcase
      return step;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dti_bicnt_dwn.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : dti_bicnt_dwn                                                |
// | Purpose   : Down counter of remaining narrow-side words in a burst.      |
// |             Each counted beat subtracts the step (1/2/4) given by the    |
// |             ratio latched at load, saturating at DOWN_TO. done flags     |
// |             that the remaining words fit in a single beat.               |
// | Ports     : clk, reset_n (async, active-low)                             |
// |             load_en   - load count_to and count_num (priority)           |
// |             count_to  - burst length in narrow words                     |
// |             count_num - ratio code selecting the step                    |
// |             count_en  - one beat consumed                                |
// |             done      - current beat is the final one                    |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module dti_bicnt_dwn
   import dti_fifo_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int DOWN_TO = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_en,
   input  logic [WIDTH-1:0] count_to,
   input  logic [1:0]       count_num,
   input  logic             count_en,
   output logic             done
);

   logic [WIDTH-1:0] count;
   logic [2:0]       step;
   logic [WIDTH:0]   count_ext;
   logic [WIDTH:0]   limit;

   // One extra bit so floor + step never wraps at the top of the range
   assign count_ext = {1'b0, count};
   assign limit     = (WIDTH+1)'(DOWN_TO) + (WIDTH+1)'(step);

   // Zero length or anything up to one step still needs exactly one beat
   assign done = (count_ext <= limit);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= WIDTH'(DOWN_TO);
         step  <= 3'd1;
      end else if (load_en) begin
         count <= count_to;
         step  <= ratio_step(count_num);
      end else if (count_en) begin
         if (count_ext > limit)
            count <= count - WIDTH'(step);
         else
            count <= WIDTH'(DOWN_TO);
      end
   end

endmodule
`default_nettype wire

// File: rtl/dti_fifo_burst_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : dti_fifo_burst_sched                                         |
// | Purpose   : Round-robin scheduler sharing one FIFO read datapath among   |
// |             NREQ burst requesters. Arbitrates, loads the beat counter    |
// |             with the winner's length/ratio, enables beats until the      |
// |             final one, then issues a one-cycle completion.               |
// | Ports     : clk, reset_n (async, active-low)                             |
// |             req[NREQ]        request, held until gnt                     |
// |             req_len[NREQ*W]  burst length, slice i = [i*W +: W]          |
// |             req_ratio[NREQ*2] words per beat: 0=1:1 1=1:2 2=1:4 3=rsvd   |
// |             gnt[NREQ]        one-hot grant during LOAD and XFER          |
// |             xfer_en          datapath may transfer beats                 |
// |             beat             one beat transferred this cycle             |
// |             last             current beat is the final one               |
// |             abort            terminate active burst                      |
// |             cmp[NREQ]        one-cycle completion pulse                  |
// |             err              with cmp: reserved ratio or abort           |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module dti_fifo_burst_sched
   import dti_fifo_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_len,
   input  logic [NREQ*2-1:0]     req_ratio,
   output logic [NREQ-1:0]       gnt,
   output logic                  xfer_en,
   input  logic                  beat,
   output logic                  last,
   input  logic                  abort,
   output logic [NREQ-1:0]       cmp,
   output logic                  err
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   sched_st_t        state, state_nxt;
   logic [PTR_W-1:0] ptr, ptr_nxt;
   logic [PTR_W-1:0] gidx, gidx_nxt;
   logic [PTR_W-1:0] pick;
   logic [NREQ-1:0]  gnt_nxt, cmp_nxt;
   logic             err_nxt;
   logic             load_en, count_en, cnt_done;
   logic [WIDTH-1:0] sel_len;
   logic [1:0]       sel_ratio;

   // Rotate the request vector down by the pointer through a double-width
   // copy, take the lowest set bit, then rotate the index back.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [NREQ-1:0]  r,
                                                input logic [PTR_W-1:0] p);
      logic [2*NREQ-1:0] dbl;
      logic [PTR_W-1:0]  idx;
      logic              found;
      dbl   = {r, r} >> p;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && dbl[k]) begin
            found = 1'b1;
            idx   = PTR_W'((k + int'(p)) % NREQ);
         end
      end
      return idx;
   endfunction

   assign pick      = rr_pick(req, ptr);
   assign sel_len   = req_len[int'(gidx)*WIDTH +: WIDTH];
   assign sel_ratio = req_ratio[int'(gidx)*2 +: 2];

   assign last     = xfer_en & cnt_done;
   // Abort overrides any concurrent beat
   assign count_en = xfer_en & beat & ~abort;

   dti_bicnt_dwn #(
      .WIDTH   (WIDTH),
      .DOWN_TO (0)
   ) u_beat_cnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_en   (load_en),
      .count_to  (sel_len),
      .count_num (sel_ratio),
      .count_en  (count_en),
      .done      (cnt_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      gidx_nxt  = gidx;
      gnt_nxt   = gnt;
      cmp_nxt   = '0;
      err_nxt   = 1'b0;
      load_en   = 1'b0;
      xfer_en   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|req) begin
               gidx_nxt  = pick;
               gnt_nxt   = NREQ'(1) << pick;
               ptr_nxt   = (pick == PTR_W'(NREQ-1)) ? '0 : pick + PTR_W'(1);
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (abort || (ratio_t'(sel_ratio) == RATIO_RSVD)) begin
               cmp_nxt   = gnt;
               err_nxt   = 1'b1;
               gnt_nxt   = '0;
               state_nxt = ST_IDLE;
            end else begin
               load_en   = 1'b1;
               state_nxt = ST_XFER;
            end
         end
         ST_XFER: begin
            xfer_en = 1'b1;
            if (abort) begin
               cmp_nxt   = gnt;
               err_nxt   = 1'b1;
               gnt_nxt   = '0;
               state_nxt = ST_IDLE;
            end else if (beat && cnt_done) begin
               cmp_nxt   = gnt;
               gnt_nxt   = '0;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            gnt_nxt   = '0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr  <= '0;
         gidx <= '0;
         gnt  <= '0;
         cmp  <= '0;
         err  <= 1'b0;
      end else begin
         ptr  <= ptr_nxt;
         gidx <= gidx_nxt;
         gnt  <= gnt_nxt;
         cmp  <= cmp_nxt;
         err  <= err_nxt;
      end
   end

endmodule
`default_nettype wire
